axi_write_sched: RTL and testbench

AXI_WRITE_SCHED -- requirements
Module: axi_write_sched

---
 rtl/axi_write_sched.sv | 167 ++++++++++++++++
 tb/tb_axi_write_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_sched.sv
// AXI write scheduler: round-robin AW arbiter whose grant order is queued so the W channel follows it.
// Define WSCHED_LAST_CHECK_EN to add the sticky w_last mismatch checker driving err_last.
module axi_write_sched #(
  parameter int NUM_MST   = 2,
  parameter int ORD_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NUM_MST-1:0]   aw_valid,
  input  logic [NUM_MST*8-1:0] aw_len,
  input  logic                 aw_o_ready,
  output logic [NUM_MST-1:0]   aw_grant,
  output logic                 aw_o_valid,
  input  logic [NUM_MST-1:0]   w_valid,
  input  logic [NUM_MST-1:0]   w_last,
  input  logic                 w_o_ready,
  output logic [NUM_MST-1:0]   w_sel,
  output logic [NUM_MST-1:0]   w_ready,
  output logic                 w_o_valid,
  output logic                 w_o_last,
  output logic                 err_last
);
  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int PTR_W = $clog2(ORD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(ORD_DEPTH);
  localparam logic [IDX_W-1:0] LAST_MST = IDX_W'(NUM_MST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  logic [NUM_MST-1:0] aw_grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;

  logic [7:0]       len_arr [NUM_MST];
  logic [IDX_W-1:0] idx_mem [ORD_DEPTH];
  logic [7:0]       len_mem [ORD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic             fifo_full, nonempty, push, pop, w_hs;
  logic [IDX_W-1:0] head_idx;
  logic [7:0]       head_len;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_mst
      assign len_arr[gi] = aw_len[gi*8 +: 8];
      assign w_sel[gi]   = nonempty && (head_idx == IDX_W'(gi));
      assign w_ready[gi] = w_sel[gi] && w_o_ready;
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping around the master list.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_MST) cand = cand - NUM_MST;
      cand_idx = IDX_W'(cand);
      if (!arb_found && aw_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign nonempty   = (count_q != '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign head_idx   = idx_mem[rd_ptr_q];
  assign head_len   = len_mem[rd_ptr_q];
  assign w_o_valid  = nonempty && w_valid[head_idx];
  assign w_o_last   = nonempty && (beat_cnt_q == head_len);
  assign w_hs       = w_o_valid && w_o_ready;
  assign pop        = w_hs && w_o_last;
  assign push       = (state_q == GRANT) && aw_o_ready;
  assign aw_grant   = aw_grant_q;
  assign aw_o_valid = (state_q == GRANT);

  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      aw_grant_q  <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found && !fifo_full) begin
            state_q     <= GRANT;
            aw_grant_q  <= NUM_MST'(1) << arb_idx;
            grant_idx_q <= arb_idx;
          end
        end
        GRANT: begin
          if (aw_o_ready) begin
            state_q    <= IDLE;
            aw_grant_q <= '0;
            rr_ptr_q   <= (grant_idx_q == LAST_MST) ? '0 : grant_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (w_hs) beat_cnt_d = w_o_last ? 8'd0 : beat_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      idx_mem[wr_ptr_q] <= grant_idx_q;
      len_mem[wr_ptr_q] <= len_arr[grant_idx_q];
    end
  end

`ifdef WSCHED_LAST_CHECK_EN
  logic err_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else if (w_hs && (w_last[head_idx] != w_o_last)) begin
      err_q <= 1'b1;
    end
  end
  assign err_last = err_q;
`else
  logic unused_w_last;
  assign unused_w_last = ^w_last;
  assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_sched.sv
// Bench for axi_write_sched: queue-based reference model checked every cycle, plus directed scenarios.
module tb_axi_write_sched;
  localparam int NM    = 2;
  localparam int DEPTH = 4;
`ifdef WSCHED_LAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [NM-1:0]   aw_valid = '0;
  logic [NM*8-1:0] aw_len = '0;
  logic            aw_o_ready = 1'b0;
  logic [NM-1:0]   aw_grant;
  logic            aw_o_valid;
  logic [NM-1:0]   w_valid = '0;
  logic [NM-1:0]   w_last = '0;
  logic            w_o_ready = 1'b0;
  logic [NM-1:0]   w_sel;
  logic [NM-1:0]   w_ready;
  logic            w_o_valid;
  logic            w_o_last;
  logic            err_last;

  axi_write_sched #(.NUM_MST(NM), .ORD_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .aw_valid(aw_valid), .aw_len(aw_len), .aw_o_ready(aw_o_ready),
    .aw_grant(aw_grant), .aw_o_valid(aw_o_valid),
    .w_valid(w_valid), .w_last(w_last), .w_o_ready(w_o_ready),
    .w_sel(w_sel), .w_ready(w_ready), .w_o_valid(w_o_valid),
    .w_o_last(w_o_last), .err_last(err_last)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Reference model: pending grant (-1 = none), ordering queue, beats done on head burst.
  typedef struct { int idx; int len; } ent_t;
  ent_t   mq[$];
  ent_t   m_e;
  int     m_pend = -1;
  int     m_rr = 0;
  int     m_beats = 0;
  int     m_sz0 = 0;
  int     m_c = 0;
  bit     m_err = 1'b0;
  bit     m_last = 1'b0;
  longint cyc = 0;

  always @(posedge CLK) cyc++;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      m_pend = -1; m_rr = 0; m_beats = 0; m_err = 1'b0;
    end else begin
      m_sz0 = mq.size();
      if (m_sz0 > 0 && w_valid[mq[0].idx] && w_o_ready) begin
        m_last = (m_beats == mq[0].len);
`ifdef WSCHED_LAST_CHECK_EN
        if (w_last[mq[0].idx] != m_last) m_err = 1'b1;
`endif
        if (m_last) begin
          void'(mq.pop_front());
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
      if (m_pend >= 0) begin
        if (aw_o_ready) begin
          m_e.idx = m_pend;
          m_e.len = int'(aw_len[m_pend*8 +: 8]);
          mq.push_back(m_e);
          m_rr = (m_pend + 1) % NM;
          m_pend = -1;
        end
      end else if (aw_valid != '0 && m_sz0 < DEPTH) begin
        for (int k = 0; k < NM; k++) begin
          m_c = (m_rr + k) % NM;
          if (m_pend < 0 && aw_valid[m_c]) m_pend = m_c;
        end
      end
    end
  end

  logic [NM-1:0] e_grant, e_sel, e_wr;
  logic          e_awv, e_wv, e_last;
  logic [NM-1:0] aw_log_g[$];
  longint        aw_log_c[$];
  logic [NM:0]   w_log[$];

  always @(negedge CLK) begin
    e_grant = '0; e_awv = 1'b0; e_sel = '0; e_wr = '0; e_wv = 1'b0; e_last = 1'b0;
    if (m_pend >= 0) begin
      e_awv = 1'b1;
      e_grant = NM'(1 << m_pend);
    end
    if (mq.size() > 0) begin
      e_sel  = NM'(1 << mq[0].idx);
      e_wv   = w_valid[mq[0].idx];
      e_wr   = w_o_ready ? e_sel : '0;
      e_last = (m_beats == mq[0].len);
    end
    check("cycle_outputs",
          32'({aw_grant, aw_o_valid, w_sel, w_ready, w_o_valid, w_o_last, err_last}),
          32'({e_grant, e_awv, e_sel, e_wr, e_wv, e_last, m_err}));
    if (aw_o_valid && aw_o_ready) begin
      aw_log_g.push_back(aw_grant);
      aw_log_c.push_back(cyc);
    end
    if (w_o_valid && w_o_ready) w_log.push_back({w_sel, w_o_last});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    aw_valid = '0; aw_len = '0; aw_o_ready = 1'b0;
    w_valid = '0; w_last = '0; w_o_ready = 1'b0;
    repeat (2) step();
    nRST = 1'b1;
    step();
  endtask

  task automatic wait_aw(input string name);
    int i;
    i = 0;
    @(negedge CLK);
    while (!aw_o_valid && i < 20) begin
      @(negedge CLK);
      i++;
    end
    if (!aw_o_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [2:0] ord_exp [6] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b101};

  initial begin
    #1;
    check("reset_state", 32'({aw_grant, aw_o_valid, w_sel, w_ready, w_o_valid, w_o_last, err_last}), 32'd0);

    // Round-robin with both masters requesting, single-beat bursts.
    do_reset();
    aw_log_g.delete(); aw_log_c.delete();
    aw_valid = 2'b11; aw_o_ready = 1'b1; w_valid = 2'b11; w_o_ready = 1'b1;
    repeat (10) step();
    aw_valid = '0;
    repeat (3) step();
    check("rr_count", 32'(aw_log_g.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < aw_log_g.size()) check($sformatf("rr_grant%0d", i), 32'(aw_log_g[i]), 32'(rr_exp[i]));
      if (i > 0 && i < aw_log_c.size()) check($sformatf("rr_gap%0d", i), 32'(aw_log_c[i] - aw_log_c[i-1]), 32'd2);
    end

    // Ordering: D$ len 3 then SP len 1.
    do_reset();
    aw_o_ready = 1'b1; aw_len = {8'd1, 8'd3}; aw_valid = 2'b01;
    wait_aw("ord_dc");
    check("ord_grant_dc", 32'(aw_grant), 32'd1);
    step();
    aw_valid = 2'b10;
    wait_aw("ord_sp");
    check("ord_grant_sp", 32'(aw_grant), 32'd2);
    step();
    aw_valid = '0;
    w_log.delete();
    w_valid = 2'b11; w_o_ready = 1'b1;
    repeat (10) step();
    w_valid = '0;
    check("ord_beats", 32'(w_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < w_log.size()) check($sformatf("ord_beat%0d", i), 32'(w_log[i]), 32'(ord_exp[i]));

    // Full FIFO blocks the fifth grant, including on the pop cycle.
    do_reset();
    aw_log_g.delete(); aw_log_c.delete();
    aw_valid = 2'b01; aw_o_ready = 1'b1;
    repeat (12) step();
    check("full_pushes", 32'(aw_log_g.size()), 32'd4);
    @(negedge CLK);
    check("full_block", 32'(aw_o_valid), 32'd0);
    step();
    w_valid = 2'b01; w_o_ready = 1'b1;
    @(posedge CLK);
    #1;
    w_valid = '0; w_o_ready = 1'b0;
    @(negedge CLK);
    check("full_pop_cycle", 32'(aw_o_valid), 32'd0);
    @(negedge CLK);
    check("full_grant_after_pop", 32'({aw_o_valid, aw_grant}), 32'b101);
    step();
    aw_valid = '0;

    // AW backpressure: grant held for 5 cycles, single push on release.
    do_reset();
    aw_len = {8'd5, 8'd0}; aw_valid = 2'b10;
    wait_aw("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), 32'({aw_o_valid, aw_grant}), 32'b110);
      @(negedge CLK);
    end
    step();
    aw_o_ready = 1'b1;
    step();
    aw_valid = '0; aw_o_ready = 1'b0;
    @(negedge CLK);
    check("bp_wsel", 32'({aw_o_valid, w_sel}), 32'b010);
    step();
    w_log.delete();
    w_valid = 2'b10; w_o_ready = 1'b1;
    repeat (8) step();
    w_valid = '0;
    @(negedge CLK);
    check("bp_beats", 32'(w_log.size()), 32'd6);
    check("bp_single_push", 32'(w_sel), 32'd0);

    // wlast checker: mismatch on beat 2 of a 3-beat burst.
    do_reset();
    aw_len = {8'd0, 8'd2}; aw_valid = 2'b01; aw_o_ready = 1'b1;
    wait_aw("chk");
    step();
    aw_valid = '0; aw_o_ready = 1'b0;
    step();
    w_valid = 2'b01; w_o_ready = 1'b1; w_last = 2'b00;
    step();
    w_last = 2'b01;
    step();
    step();
    w_valid = '0; w_last = '0;
    @(negedge CLK);
    check("chk_err_set", 32'(err_last), 32'(EXP_ERR));
    repeat (3) step();
    check("chk_err_held", 32'(err_last), 32'(EXP_ERR));

    // Reset mid-burst with three queued entries.
    do_reset();
    aw_len = {8'd2, 8'd2}; aw_valid = 2'b01; aw_o_ready = 1'b1;
    repeat (6) step();
    aw_valid = '0;
    w_valid = 2'b01; w_o_ready = 1'b1;
    step();
    nRST = 1'b0;
    #1;
    check("reset_async_outputs", 32'({aw_grant, aw_o_valid, w_sel, w_ready, w_o_valid, w_o_last, err_last}), 32'd0);
    repeat (2) step();
    nRST = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    check("reset_wsel_empty", 32'({w_sel, w_o_valid}), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      step();
      aw_valid = NM'($urandom);
      if (aw_o_valid) aw_valid = aw_valid | aw_grant;
      aw_len = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      aw_o_ready = ($urandom_range(0, 2) != 0);
      w_valid = NM'($urandom);
      w_last = NM'($urandom);
      w_o_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    aw_valid = '0; w_valid = '0;
`ifndef WSCHED_LAST_CHECK_EN
    @(negedge CLK);
    check("rand_err_tied", 32'(err_last), 32'd0);
`endif
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
